cic_decim_ctrl: RTL

Sequencing and configuration controller for the 5-stage CIC decimator in the DFE filter array. Owns the decimation phase counter, a runtime-programmable ratio with glitch-free apply at a decimation boundary, a datapath clear sequence on enable, and output-valid gating while the comb pipeline refills. Sits between the register/config interface and the CIC datapath; drives the datapath's reset, clock-enable and decimation strobe.

---
 rtl/cic_decim_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cic_decim_ctrl.sv
// +---------------------------------------------------------------------------+
// | cic_decim_ctrl                                                            |
// | Phase/ratio/clear/fill sequencing for the 5-stage CIC decimator.          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module cic_decim_ctrl #(
  parameter int MAX_R      = 4096,
  parameter int DEFAULT_R  = 8,
  parameter int CLR_CYCLES = 4,
  parameter int FILL_OUTS  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_ratio,
  input  logic        cfg_err_clr,
  output logic        cic_rst,
  output logic        cic_ce,
  output logic        dec_strobe,
  output logic        out_valid,
  output logic [15:0] ratio_active,
  output logic        cfg_pending,
  output logic        cfg_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [15:0] c_default_r = 16'(DEFAULT_R);
  localparam logic [15:0] c_max_r     = 16'(MAX_R);
  localparam logic [7:0]  c_clr_last  = 8'(CLR_CYCLES - 1);
  localparam logic [7:0]  c_fill_last = 8'(FILL_OUTS - 1);

  state_t      r_state;
  logic [15:0] r_phase;
  logic [15:0] r_shadow;
  logic [7:0]  r_clr;
  logic [7:0]  r_fill;

  logic w_active;
  logic w_wrap;
  logic w_legal;
  logic w_wr_ok;
  logic w_wr_bad;

  assign w_active = (r_state == S_FILL) || (r_state == S_RUN);
  assign cic_ce   = in_valid & w_active;
  assign w_wrap   = cic_ce && (r_phase == ratio_active - 16'd1);
  assign w_legal  = (cfg_ratio != 16'd0) && (cfg_ratio <= c_max_r);
  assign w_wr_ok  = cfg_wr & w_legal;
  assign w_wr_bad = cfg_wr & ~w_legal;
  assign state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= 16'd0;
      r_shadow     <= c_default_r;
      r_clr        <= 8'd0;
      r_fill       <= 8'd0;
      cic_rst      <= 1'b1;
      dec_strobe   <= 1'b0;
      out_valid    <= 1'b0;
      ratio_active <= c_default_r;
      cfg_pending  <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      dec_strobe <= w_wrap;
      out_valid  <= w_wrap && (r_state == S_RUN);

      // An illegal write on the same cycle as a clear keeps the flag set.
      if (w_wr_bad) begin
        cfg_err <= 1'b1;
      end else if (cfg_err_clr) begin
        cfg_err <= 1'b0;
      end

      if (!en) begin
        r_state     <= S_IDLE;
        cic_rst     <= 1'b1;
        r_phase     <= 16'd0;
        r_fill      <= 8'd0;
        r_clr       <= 8'd0;
        cfg_pending <= 1'b0;
        // Leaving the datapath: the newest legal ratio takes effect at once.
        if (w_wr_ok) begin
          ratio_active <= cfg_ratio;
        end else if (cfg_pending) begin
          ratio_active <= r_shadow;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CLEAR;
            cic_rst <= 1'b1;
            r_clr   <= 8'd0;
            if (w_wr_ok) begin
              ratio_active <= cfg_ratio;
            end
          end

          S_CLEAR: begin
            if (w_wr_ok) begin
              ratio_active <= cfg_ratio;
            end
            if (r_clr == c_clr_last) begin
              r_state <= S_FILL;
              cic_rst <= 1'b0;
              r_phase <= 16'd0;
              r_fill  <= 8'd0;
            end else begin
              r_clr <= r_clr + 8'd1;
            end
          end

          default: begin
            if (cic_ce) begin
              r_phase <= w_wrap ? 16'd0 : r_phase + 16'd1;
            end

            // A ratio change restarts the comb refill without clearing the CIC.
            if (w_wrap && cfg_pending) begin
              ratio_active <= r_shadow;
              r_fill       <= 8'd0;
              r_state      <= S_FILL;
            end else if (w_wrap && (r_state == S_FILL)) begin
              if (r_fill == c_fill_last) begin
                r_state <= S_RUN;
              end else begin
                r_fill <= r_fill + 8'd1;
              end
            end

            if (w_wr_ok) begin
              r_shadow    <= cfg_ratio;
              cfg_pending <= 1'b1;
            end else if (w_wrap) begin
              cfg_pending <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
